sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL take parameter DEPTH, default 4, max outstanding accepted-but-unanswered requests (power of two, >=2).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have inst_req  input  1  instruction-fetch read request.
REQ-005 SHALL have inst_addr  input  32  instruction-fetch address.
REQ-006 SHALL have inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 SHALL have inst_data_ok  output  1  instruction read data valid this cycle.
REQ-008 SHALL have inst_rdata  output  32  instruction read data.
REQ-009 SHALL have data_req  input  1  load/store request.
REQ-010 SHALL have data_wr  input  1  1 = store, 0 = load.
REQ-011 SHALL have data_wstrb  input  4  store byte enables.
REQ-012 SHALL have data_addr  input  32  load/store address.
REQ-013 SHALL have data_wdata  input  32  store data.
REQ-014 SHALL have data_addr_ok  output  1  data request accepted this cycle.
REQ-015 SHALL have data_data_ok  output  1  load data returned / store completed this cycle.
REQ-016 SHALL have data_rdata  output  32  load data.
REQ-017 SHALL have mem_req  output  1  request to shared memory port.
REQ-018 SHALL have mem_wr  output  1  forwarded write flag.
REQ-019 SHALL have mem_wstrb  output  4  forwarded byte enables.
REQ-020 SHALL have mem_addr  output  32  forwarded address.
REQ-021 SHALL have mem_wdata  output  32  forwarded write data.
REQ-022 SHALL have mem_addr_ok  input  1  memory accepted mem_req this cycle.
REQ-023 SHALL have mem_data_ok, mem_rdata  input  1/32  in-order response strobe and data from memory.

Function
REQ-024 SHALL select source sel: if hold_valid, sel = hold_sel; else data if data_req, else inst if inst_req.
REQ-025 SHALL drive mem_req = selected request && !fifo_full; mem_wr/mem_wstrb/mem_addr/mem_wdata from selected master; instruction selection forces mem_wr=0, mem_wstrb=4'b0, mem_wdata=0.
REQ-026 SHALL set hold_valid, hold_sel<=sel when mem_req && !mem_addr_ok; clear hold_valid on mem_req && mem_addr_ok (a presented request is never pre-empted, even by data_req).
REQ-027 SHALL assert {inst,data}_addr_ok = mem_req && mem_addr_ok && sel==that master; combinational, zero added latency.
REQ-028 SHALL push sel (1 bit, 1=data) into an in-order ID FIFO of DEPTH entries on each accepted handshake (mem_req && mem_addr_ok).
REQ-029 SHALL, on mem_data_ok with FIFO non-empty, pop head and assert data_data_ok if head=1 else inst_data_ok, same cycle; other master's data_ok stays 0.
REQ-030 SHALL drive inst_rdata = data_rdata = mem_rdata unconditionally.
REQ-031 SHALL ignore mem_data_ok when FIFO empty: no pop, both data_ok 0, count unchanged (pop evaluated on pre-push state).
REQ-032 SHALL allow push and pop in the same cycle: count unchanged, pointers both advance, wrap modulo DEPTH.
REQ-033 SHALL, when count==DEPTH, hold mem_req=0 and both addr_ok=0; requests resume the cycle after a pop.
REQ-034 SHALL keep count in clog2(DEPTH)+1 bits; never exceed DEPTH nor underflow.

Reset
REQ-035 SHALL, while resetn=0 (asserted asynchronously, released synchronously by design), clear hold_valid, hold_sel, FIFO pointers and count; mem_req, all addr_ok and data_ok outputs SHALL be 0 during reset; responses to pre-reset requests arriving after reset are dropped per REQ-031.

Verification
REQ-036 SHALL cover: inst_req=data_req=1, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr; next cycle inst accepted.
REQ-037 SHALL cover: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises cycle 2 -> mem_addr stays inst_addr until accept; data accepted cycle after.
REQ-038 SHALL cover: DEPTH=4, 4 accepts with no mem_data_ok -> count=4, mem_req=0 with pending req; one mem_data_ok -> next cycle mem_req=1.
REQ-039 SHALL cover: order inst,data,inst accepted, three mem_data_ok with rdata 0x11,0x22,0x33 -> inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
REQ-040 SHALL cover: simultaneous accept and mem_data_ok at count=2 -> count stays 2; mem_data_ok at count=0 -> no data_ok; resetn low mid-burst -> count=0, all strobes 0 immediately.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Shared bus bundle between the two CPU-side masters, the arbiter and the SRAM port.
// slave = arbiter view; master = the CPU/memory side that drives requests and responses.
interface sram_arbiter_if;
    // instruction-fetch master
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    // load/store master
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // shared memory port
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates instruction-fetch and load/store masters onto one in-order SRAM port, data first.
// Zero added latency on accept and response strobes; mem_req is withheld while DEPTH responses are outstanding.
module sram_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    sram_arbiter_if.slave bus
);
    localparam int   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int   CW       = $clog2(DEPTH) + 1;
    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    logic             hold_valid_q, hold_valid_d;
    logic             hold_sel_q, hold_sel_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] id_q, id_d;

    logic sel;
    logic sel_req;
    logic fifo_full;
    logic fifo_empty;
    logic req_out;
    logic accept;
    logic pop;
    logic head;

    // A request that has been presented but not accepted keeps the port until it is taken.
    always_comb begin
        sel     = SEL_INST;
        sel_req = 1'b0;
        if (hold_valid_q) begin
            sel     = hold_sel_q;
            sel_req = hold_sel_q ? bus.data_req : bus.inst_req;
        end else if (bus.data_req) begin
            sel     = SEL_DATA;
            sel_req = 1'b1;
        end else if (bus.inst_req) begin
            sel     = SEL_INST;
            sel_req = 1'b1;
        end
    end

    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // resetn gates the combinational strobes so nothing escapes while the flops are held in reset.
    assign req_out = resetn && sel_req && !fifo_full;
    assign accept  = req_out && bus.mem_addr_ok;
    assign pop     = resetn && bus.mem_data_ok && !fifo_empty;
    assign head    = id_q[rd_ptr_q];

    assign bus.mem_req   = req_out;
    assign bus.mem_wr    = (sel == SEL_DATA) ? bus.data_wr    : 1'b0;
    assign bus.mem_wstrb = (sel == SEL_DATA) ? bus.data_wstrb : 4'b0000;
    assign bus.mem_addr  = (sel == SEL_DATA) ? bus.data_addr  : bus.inst_addr;
    assign bus.mem_wdata = (sel == SEL_DATA) ? bus.data_wdata : 32'h0;

    assign bus.inst_addr_ok = accept && (sel == SEL_INST);
    assign bus.data_addr_ok = accept && (sel == SEL_DATA);

    assign bus.inst_data_ok = pop && (head == SEL_INST);
    assign bus.data_data_ok = pop && (head == SEL_DATA);
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_sel_d   = hold_sel_q;
        if (req_out && !bus.mem_addr_ok) begin
            hold_valid_d = 1'b1;
            hold_sel_d   = sel;
        end else if (accept) begin
            hold_valid_d = 1'b0;
        end
    end

    // Response-ID FIFO: one bit per outstanding request, answered strictly in order.
    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_valid_q <= 1'b0;
            hold_sel_q   <= SEL_INST;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_sel_q   <= hold_sel_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
        end
    end
endmodule
